// File: rtl/trap_pkg.sv
// trap_pkg: shared state type and CSR/cause constants for the trap sequencer.
package trap_pkg;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_ENTRY    = 2'd1,
        S_EXIT     = 2'd2,
        S_REDIRECT = 2'd3
    } state_e;

    localparam logic [3:0] IRQ_CODE_SW    = 4'd3;
    localparam logic [3:0] IRQ_CODE_TIMER = 4'd7;
    localparam logic [3:0] IRQ_CODE_EXT   = 4'd11;

    localparam int MSTATUS_MIE = 3;
    localparam int MIE_MSIE    = 3;
    localparam int MIE_MTIE    = 7;
    localparam int MIE_MEIE    = 11;
    localparam int MIP_MSIP    = 3;
    localparam int MIP_MTIP    = 7;
    localparam int MIP_MEIP    = 11;

    localparam logic [3:0] EXC_INST_MISALIGN  = 4'd0;
    localparam logic [3:0] EXC_INST_FAULT     = 4'd1;
    localparam logic [3:0] EXC_ILLEGAL_INST   = 4'd2;
    localparam logic [3:0] EXC_BREAKPOINT     = 4'd3;
    localparam logic [3:0] EXC_LOAD_MISALIGN  = 4'd4;
    localparam logic [3:0] EXC_LOAD_FAULT     = 4'd5;
    localparam logic [3:0] EXC_STORE_MISALIGN = 4'd6;
    localparam logic [3:0] EXC_STORE_FAULT    = 4'd7;
    localparam logic [3:0] EXC_ECALL_U        = 4'd8;
    localparam logic [3:0] EXC_ECALL_S        = 4'd9;
    localparam logic [3:0] EXC_RESERVED_10    = 4'd10;
    localparam logic [3:0] EXC_ECALL_M        = 4'd11;

endpackage

// File: rtl/trap_prio_enc.sv
// trap_prio_enc: fixed-priority machine interrupt selector (Ext > Sw > Timer).
//   pend_i  : pending bits {ext, sw, timer}
//   en_i    : enable bits  {ext, sw, timer}
//   gate_i  : global gate (MIE and instruction boundary)
//   valid_o : some interrupt is eligible
//   code_o  : cause code of the winning interrupt
module trap_prio_enc
    import trap_pkg::*;
(
    input  logic [2:0] pend_i,
    input  logic [2:0] en_i,
    input  logic       gate_i,
    output logic       valid_o,
    output logic [3:0] code_o
);
    logic [2:0] elig;

    always_comb begin
        elig    = pend_i & en_i & {3{gate_i}};
        valid_o = |elig;
        code_o  = elig[2] ? IRQ_CODE_EXT :
                  elig[1] ? IRQ_CODE_SW :
                  elig[0] ? IRQ_CODE_TIMER : 4'd0;
    end
endmodule

// File: rtl/trap_ctrl.sv
// trap_ctrl: machine-mode trap sequencer feeding the CSR file and fetch redirect.
//   Inputs : Clk, Rst_n (async, active-low), CsrStatus/CsrIe/CsrTvec/CsrEpc CSR images,
//            IrqSw/IrqTimer/IrqExt level interrupts, InstBoundary, NextPC,
//            ExcValid/ExcCode/ExcPC/ExcTval exception request, MretValid, RedirectAck.
//   Outputs: IntEntry/IntExit strobes, IntCause/IntPC/IntMtval, CsrPending (mip),
//            RedirectValid/RedirectPC handshake, Busy.
//   Build option: define TRAP_VECTORED_EN to honour vectored mtvec mode for interrupts.
module trap_ctrl
    import trap_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        Clk,
    input  logic        Rst_n,
    input  logic [31:0] CsrStatus,
    input  logic [31:0] CsrIe,
    input  logic [31:0] CsrTvec,
    input  logic [31:0] CsrEpc,
    input  logic        IrqSw,
    input  logic        IrqTimer,
    input  logic        IrqExt,
    input  logic        InstBoundary,
    input  logic [31:0] NextPC,
    input  logic        ExcValid,
    input  logic [3:0]  ExcCode,
    input  logic [31:0] ExcPC,
    input  logic [31:0] ExcTval,
    input  logic        MretValid,
    input  logic        RedirectAck,
    output logic        IntEntry,
    output logic        IntExit,
    output logic [31:0] IntCause,
    output logic [31:0] IntPC,
    output logic [31:0] IntMtval,
    output logic [31:0] CsrPending,
    output logic        RedirectValid,
    output logic [31:0] RedirectPC,
    output logic        Busy
);
    state_e      state_q, state_d;
    logic [31:0] cause_q, cause_d, pc_q, pc_d, tval_q, tval_d, rpc_q, rpc_d;
    logic [2:0]  pend_q;
    logic        entry_q, exit_q, rvalid_q, busy_q;
    logic        irq_v;
    logic [3:0]  irq_code;
    logic [31:0] base, irq_tgt;
    logic        unused_ok;

    trap_prio_enc u_prio (
        .pend_i  (pend_q),
        .en_i    ({CsrIe[MIE_MEIE], CsrIe[MIE_MSIE], CsrIe[MIE_MTIE]}),
        .gate_i  (CsrStatus[MSTATUS_MIE] & InstBoundary),
        .valid_o (irq_v),
        .code_o  (irq_code)
    );

    assign base = {CsrTvec[31:2], 2'b00};
`ifdef TRAP_VECTORED_EN
    assign irq_tgt = (CsrTvec[1:0] == 2'b01) ? base + {26'b0, irq_code, 2'b00} : base;
`else
    assign irq_tgt = base;
`endif
    // CSR images are only partially decoded here.
    assign unused_ok = ^{CsrStatus, CsrIe, CsrTvec[1:0], CsrEpc[1:0]};

    always_comb begin
        state_d = state_q;
        cause_d = cause_q;
        pc_d    = pc_q;
        tval_d  = tval_q;
        rpc_d   = rpc_q;
        case (state_q)
            S_IDLE: begin
                if (ExcValid) begin
                    state_d = S_ENTRY;
                    cause_d = {28'b0, ExcCode};
                    pc_d    = ExcPC;
                    tval_d  = ExcTval;
                    rpc_d   = base;
                end else if (MretValid) begin
                    state_d = S_EXIT;
                    rpc_d   = {CsrEpc[31:2], 2'b00};
                end else if (irq_v) begin
                    state_d = S_ENTRY;
                    cause_d = {1'b1, 27'b0, irq_code};
                    pc_d    = NextPC;
                    tval_d  = '0;
                    rpc_d   = irq_tgt;
                end
            end
            S_ENTRY, S_EXIT: state_d = S_REDIRECT;
            default: begin
                if (RedirectAck) begin
                    state_d = S_IDLE;
                    rpc_d   = RESET_PC;
                end
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q  <= S_IDLE;
            cause_q  <= '0;
            pc_q     <= '0;
            tval_q   <= '0;
            rpc_q    <= RESET_PC;
            pend_q   <= '0;
            entry_q  <= 1'b0;
            exit_q   <= 1'b0;
            rvalid_q <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cause_q  <= cause_d;
            pc_q     <= pc_d;
            tval_q   <= tval_d;
            rpc_q    <= rpc_d;
            pend_q   <= {IrqExt, IrqSw, IrqTimer};
            entry_q  <= state_d == S_ENTRY;
            exit_q   <= state_d == S_EXIT;
            rvalid_q <= state_d == S_REDIRECT;
            busy_q   <= state_d != S_IDLE;
        end
    end

    always_comb begin
        CsrPending           = '0;
        CsrPending[MIP_MEIP] = pend_q[2];
        CsrPending[MIP_MSIP] = pend_q[1];
        CsrPending[MIP_MTIP] = pend_q[0];
    end

    assign IntEntry      = entry_q;
    assign IntExit       = exit_q;
    assign IntCause      = cause_q;
    assign IntPC         = pc_q;
    assign IntMtval      = tval_q;
    assign RedirectValid = rvalid_q;
    assign RedirectPC    = rpc_q;
    assign Busy          = busy_q;
endmodule

// File: doc/trap_ctrl.md
# trap_ctrl

Machine-mode trap sequencer that sits directly upstream of the CSR file. It turns core exception requests, `mret` requests and the three level-sensitive machine interrupt lines into the `IntEntry`/`IntExit` strobes and the `IntCause`/`IntPC`/`IntMtval` values that the CSR file consumes. It then hands the fetch stage a redirect PC through a valid/ack handshake. It reads `CsrStatus`, `CsrIe`, `CsrTvec` and `CsrEpc` back from the CSR file.

## Interface
Parameters:
- `RESET_PC`, default 32'h0000_0000: value driven on `RedirectPC` while idle and out of reset.

Ports:
- `Clk` in 1: the block's single clock.
- `Rst_n` in 1: asynchronous, active-low reset.
- `CsrStatus` in 32: mstatus image; bit 3 is MIE.
- `CsrIe` in 32: mie image; bits 3, 7 and 11 are MSIE, MTIE and MEIE.
- `CsrTvec` in 32: mtvec image; bits 1:0 are the mode.
- `CsrEpc` in 32: mepc image.
- `IrqSw`, `IrqTimer`, `IrqExt` in 1 each: level-sensitive machine interrupt lines.
- `InstBoundary` in 1: the core is between instructions, so an interrupt may be taken here.
- `NextPC` in 32: PC of the next instruction; saved for interrupts.
- `ExcValid` in 1: synchronous exception request.
- `ExcCode` in 4: exception cause code.
- `ExcPC` in 32: PC of the faulting instruction.
- `ExcTval` in 32: trap value for the exception.
- `MretValid` in 1: `mret` request.
- `RedirectAck` in 1: fetch has accepted `RedirectPC`.
- `IntEntry` out 1: one-cycle trap-entry strobe to the CSR file.
- `IntExit` out 1: one-cycle trap-exit strobe to the CSR file.
- `IntCause` out 32: mcause value.
- `IntPC` out 32: mepc value.
- `IntMtval` out 32: mtval value.
- `CsrPending` out 32: mip image; only bits 3, 7 and 11 can be set.
- `RedirectValid` out 1: `RedirectPC` is valid.
- `RedirectPC` out 32: new fetch address.
- `Busy` out 1: high whenever the state machine is not in IDLE.

## Operation
- States: IDLE, ENTRY, EXIT, REDIRECT. The state encoding is 2-bit.
- Pending register: `CsrPending[11]`, `[3]` and `[7]` are registered copies of `IrqExt`, `IrqSw` and `IrqTimer`. They update every cycle in every state.
- Interrupt eligibility: pending bit AND the matching `CsrIe` bit AND `CsrStatus[3]` AND `InstBoundary`.
- Interrupt priority: Ext (code 11), then Sw (code 3), then Timer (code 7).
- Request priority in IDLE: `ExcValid`, then `MretValid`, then an eligible interrupt.
- Exception, IDLE→ENTRY. Latch:
  - `IntCause` = {28'b0, `ExcCode`}
  - `IntPC` = `ExcPC`
  - `IntMtval` = `ExcTval`
- Interrupt, IDLE→ENTRY. Latch:
  - `IntCause` = {1'b1, 27'b0, code}
  - `IntPC` = `NextPC`
  - `IntMtval` = 0
- Redirect target on entry: computed and latched on the same IDLE→ENTRY edge. The base is {`CsrTvec[31:2]`, 2'b00}.
- `mret`, IDLE→EXIT. Latch `RedirectPC` = {`CsrEpc[31:2]`, 2'b00}. `IntCause`, `IntPC` and `IntMtval` keep their previous values.
- ENTRY→REDIRECT and EXIT→REDIRECT are unconditional after one cycle.
- REDIRECT→IDLE happens on the cycle where `RedirectAck` is high. `RedirectValid` stays high and `RedirectPC` stays stable until then.
- Requests arriving outside IDLE are ignored. The core holds `ExcValid` and `MretValid` while `Busy` is high.

## Timing
- Reset values:
  - state = IDLE
  - `IntEntry`, `IntExit`, `RedirectValid`, `Busy` = 0
  - `IntCause`, `IntPC`, `IntMtval`, `CsrPending` = 0
  - `RedirectPC` = `RESET_PC`
- All outputs are registered.
- Latencies:
  - IRQ line to `CsrPending`: 1 cycle.
  - `CsrPending` to `IntEntry`: 1 cycle, when eligible.
  - `ExcValid` sampled to `IntEntry` high: 1 cycle.
  - `IntEntry` high to `RedirectValid` high: 1 cycle.
- `IntEntry` and `IntExit` are each high for exactly one cycle. They are never high together.
- `RedirectAck` in the same cycle `RedirectValid` first rises: return to IDLE on the next edge. Minimum trap occupancy is 3 cycles.
- `ExcValid` and `MretValid` high together: take the exception; `mret` is dropped.
- Reset asserted mid-trap: return to IDLE immediately and drop the outstanding redirect. The CSR file is not written.
- An IRQ line deasserting after entry has no effect on the trap in flight.

## Configuration
- `TRAP_VECTORED_EN` defined: when `CsrTvec[1:0]`==2'b01 and the trap is an interrupt, the target is base + (code << 2), with wrap-around modulo 2^32. Exceptions always use the base.
- `TRAP_VECTORED_EN` undefined: the mode bits are ignored and every trap targets the base.

## Structure
- Shared package `trap_pkg` holds:
  - state typedef
  - interrupt code constants (3, 7, 11)
  - mstatus/mie/mip bit-index constants
  - exception code constants (0 through 11)
- Sub-module `trap_prio_enc`: combinational pending/enable/MIE to {valid, code[3:0]} priority encoder.

## Test plan
- `IrqTimer`=1, `CsrIe[7]`=1, `CsrStatus[3]`=1, `InstBoundary`=1, `NextPC`=32'h100, `CsrTvec`=32'h2000 → `IntEntry` for 1 cycle with `IntCause`=32'h8000_0007 and `IntPC`=32'h100, then `RedirectPC`=32'h2000.
- Same setup with `CsrTvec`=32'h2001 and `TRAP_VECTORED_EN` defined → `RedirectPC`=32'h201C. With the macro undefined → `RedirectPC`=32'h2000.
- `ExcValid` with `ExcCode`=2, `ExcPC`=32'h40, `ExcTval`=32'hDEAD, held in the same cycle as `MretValid` and `IrqExt` (eligible) → exception taken: `IntCause`=2, `IntMtval`=32'hDEAD. No `IntExit`.
- `MretValid`, `CsrEpc`=32'h1236 → `IntExit` for 1 cycle, `RedirectPC`=32'h1234. `RedirectAck` held low for 5 cycles → `RedirectValid` and `RedirectPC` remain stable throughout.
- All three IRQs pending, all enabled → `IntCause`=32'h8000_000B. With `CsrStatus[3]`=0 → no entry, and `CsrPending`=32'h0000_0888.
- `Rst_n` pulsed low while in REDIRECT → `RedirectValid`=0 and `Busy`=0 immediately, and `RedirectPC`=`RESET_PC`.
